// File: rtl/ex_muldiv_stall_pkg.sv
// Shared MDU defines: stall bus width, op encodings, iteration count and FSM/control types.
// The MULT/MULTU encodings are only executed here when MDU_MULT_EN is defined.
package ex_muldiv_stall_pkg;

    localparam int STALL_BUS_W = 6;
    localparam int MDU_ITER    = 32;

    typedef enum logic [1:0] {
        MDU_DIV   = 2'b00,
        MDU_DIVU  = 2'b01,
        MDU_MULT  = 2'b10,
        MDU_MULTU = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mdu_state_e;

    // Per-operation control captured at start and used for exit correction.
    typedef struct packed {
        logic is_mult;
        logic neg_q;     // quotient / product negated
        logic neg_r;     // remainder negated (dividend sign)
        logic div_zero;
    } mdu_ctl_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_stall_sign_fix.sv
// Combinational sign handling for the MDU: magnitude of operands on entry,
// negation of quotient/remainder or 64-bit product on exit.
module mdu_sign_fix #(
    parameter int DATA_W = 32
) (
    input  logic              is_signed,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              sgn_rs,
    output logic              sgn_rt,
    output logic [DATA_W-1:0] abs_rs,
    output logic [DATA_W-1:0] abs_rt,
    input  logic              is_mult,
    input  logic              neg_q,
    input  logic              neg_r,
    input  logic [DATA_W-1:0] raw_hi,
    input  logic [DATA_W-1:0] raw_lo,
    output logic [DATA_W-1:0] fix_hi,
    output logic [DATA_W-1:0] fix_lo
);

    logic [2*DATA_W-1:0] prod, prod_neg;

    always_comb begin
        sgn_rs = is_signed & rs[DATA_W-1];
        sgn_rt = is_signed & rt[DATA_W-1];
        abs_rs = sgn_rs ? -rs : rs;
        abs_rt = sgn_rt ? -rt : rt;

        prod     = {raw_hi, raw_lo};
        prod_neg = -prod;
        if (is_mult) begin
            {fix_hi, fix_lo} = neg_q ? prod_neg : prod;
        end else begin
            fix_lo = neg_q ? -raw_lo : raw_lo;
            fix_hi = neg_r ? -raw_hi : raw_hi;
        end
    end

endmodule

// File: rtl/ex_muldiv_stall.sv
// Iterative EX-stage divider (multiply too when MDU_MULT_EN is defined) that
// holds stallreq_from_ex while busy and drops it in the cycle the result is presented.
module ex_muldiv_stall
    import ex_muldiv_stall_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITER   = MDU_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic              stallreq_from_ex,
    output logic              ready_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(ITER);

    mdu_state_e        state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q, quo_q, opnd_q;
    mdu_ctl_t          ctl_q;
    logic              op_valid, accept, last_step;

    logic              sgn_rs, sgn_rt;
    logic [DATA_W-1:0] abs_rs, abs_rt, fix_hi, fix_lo;
    logic [DATA_W-1:0] rem_nx, quo_nx;
    logic [DATA_W+1:0] div_diff;
    logic [DATA_W:0]   div_shift;

`ifdef MDU_MULT_EN
    assign op_valid = 1'b1;
`else
    assign op_valid = ~op_i[1];
`endif

    assign last_step = (cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        stallreq_from_ex = 1'b0;
        ready_o          = 1'b0;
        accept           = 1'b0;
        case (state)
            S_IDLE: begin
                // Combinational so the controller freezes EX on this very edge.
                if (start_i && op_valid) begin
                    stallreq_from_ex = 1'b1;
                    accept           = 1'b1;
                    state_nx         = S_BUSY;
                end
            end
            S_BUSY: begin
                stallreq_from_ex = 1'b1;
                if (last_step) state_nx = S_DONE;
            end
            S_DONE: begin
                ready_o  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // One iteration: restoring shift-subtract, or shift-add with product in {rem,quo}.
    always_comb begin
        div_shift = {rem_q, quo_q[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        if (!div_diff[DATA_W+1]) begin
            rem_nx = div_diff[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nx = div_shift[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b0};
        end
`ifdef MDU_MULT_EN
        if (ctl_q.is_mult) begin
            logic [DATA_W:0] sum;
            sum    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
            rem_nx = sum[DATA_W:1];
            quo_nx = {sum[0], quo_q[DATA_W-1:1]};
        end
`endif
    end

    mdu_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
        .is_signed (op_is_signed(op_i)),
        .rs        (rs_i),
        .rt        (rt_i),
        .sgn_rs    (sgn_rs),
        .sgn_rt    (sgn_rt),
        .abs_rs    (abs_rs),
        .abs_rt    (abs_rt),
        .is_mult   (ctl_q.is_mult),
        .neg_q     (ctl_q.neg_q),
        .neg_r     (ctl_q.neg_r),
        .raw_hi    (rem_nx),
        .raw_lo    (quo_nx),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            opnd_q <= '0;
            ctl_q  <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            if (accept) begin
                // Div: quo shifts out |rs| while quotient bits shift in; mult: quo holds |rt|.
                quo_q          <= op_i[1] ? abs_rt : abs_rs;
                opnd_q         <= op_i[1] ? abs_rs : abs_rt;
                rem_q          <= '0;
                cnt            <= '0;
                ctl_q.is_mult  <= op_i[1];
                ctl_q.neg_q    <= sgn_rs ^ sgn_rt;
                ctl_q.neg_r    <= sgn_rs;
                ctl_q.div_zero <= ~op_i[1] & (rt_i == '0);
            end else if (state == S_BUSY) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt   <= cnt + CNT_W'(1);
                if (last_step) begin
                    // Remainder of x/0 naturally ends as x after sign fix.
                    hi_o <= fix_hi;
                    lo_o <= ctl_q.div_zero ? '1 : fix_lo;
                end
            end
        end
    end

endmodule
